kv_front_end_transit: RTL and testbench

Ingress splitter between the UDP receive path and the key-value store back end. It accepts 512-bit AXI-Stream request packets and parses the 128-bit request header in the first beat. Each request yields one key record on the key stream. For SET requests it takes a storage pointer from the free-pointer allocator and forwards every payload beat, tagged with that pointer, on the value stream.

---
 rtl/kv_front_end_pkg.sv | 39 +++
 rtl/kv_axis_out_reg.sv | 34 +++
 rtl/kv_front_end_transit.sv | 119 +++++++++++
 tb/tb_kv_front_end_transit.sv | 396 +++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/kv_front_end_pkg.sv
// Shared constants, header field offsets and FSM states for the KV store ingress splitter.
package kv_front_end_pkg;

  localparam int DATA_W    = 512;
  localparam int KEEP_W    = 64;
  localparam int PTR_W     = 16;
  localparam int KEY_W     = 64;
  localparam int KEY_REC_W = 81;
  localparam int VAL_REC_W = 544;

  localparam int HDR_MAGIC_LSB  = 0;
  localparam int HDR_RSVD_LSB   = 16;
  localparam int HDR_TOTLEN_LSB = 32;
  localparam int HDR_KEYLEN_LSB = 48;
  localparam int HDR_OPC_LSB    = 56;
  localparam int HDR_META_LSB   = 64;
  localparam int HDR_KEY_LSB    = 128;

  localparam logic [7:0]  OPC_SET = 8'h01;
  localparam logic [15:0] MAGIC   = 16'hFFFF;

  typedef enum logic [1:0] {
    ST_HDR,
    ST_VALUE,
    ST_DROP
  } state_e;

  // Bytes whose keep bit is clear are forced to zero before they reach storage.
  function automatic logic [DATA_W-1:0] maskBytes(input logic [DATA_W-1:0] data,
                                                  input logic [KEEP_W-1:0] keep);
    logic [DATA_W-1:0] res;
    res = '0;
    for (int i = 0; i < KEEP_W; i++) begin
      res[i*8 +: 8] = keep[i] ? data[i*8 +: 8] : 8'h00;
    end
    return res;
  endfunction

endpackage

// File: rtl/kv_axis_out_reg.sv
// Single-entry valid/ready output register; the slot accepts a new load whenever it is empty or draining.
module kv_axis_out_reg #(
  parameter int W = 8
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         load_i,
  input  logic [W-1:0] data_i,
  input  logic         ready_i,
  output logic         valid_o,
  output logic [W-1:0] data_o,
  output logic         free_o
);

  logic         valid_q;
  logic [W-1:0] data_q;

  assign free_o  = !valid_q || ready_i;
  assign valid_o = valid_q;
  assign data_o  = data_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      valid_q <= 1'b0;
      data_q  <= '0;
    end else if (load_i) begin
      valid_q <= 1'b1;
      data_q  <= data_i;
    end else if (ready_i) begin
      valid_q <= 1'b0;
    end
  end

endmodule

// File: rtl/kv_front_end_transit.sv
// Splits request packets into key records and pointer-tagged value beats.
// Define FRONT_END_HDR_CHECK_EN to drop packets whose header fails sanity checks.
module kv_front_end_transit
  import kv_front_end_pkg::*;
(
  input  logic         clk,
  input  logic         rst,
  input  logic [511:0] s_axis_tdata,
  input  logic         s_axis_tvalid,
  output logic         s_axis_tready,
  input  logic         s_axis_tlast,
  input  logic [63:0]  s_axis_tkeep,
  input  logic [15:0]  s_free_pointer,
  input  logic         s_free_pointer_valid,
  output logic         s_free_pointer_ready,
  output logic [80:0]  m_key_data,
  output logic         m_key_valid,
  input  logic         m_key_ready,
  output logic [543:0] m_value_data,
  output logic         m_value_valid,
  input  logic         m_value_ready
);

  state_e                 state_q;
  logic [PTR_W-1:0]       ptr_q;
  logic [15:0]            beatIdx_q;

  logic                   keyFree, valFree;
  logic                   isSet, hdrOk, hdrReady;
  logic                   hdrAccept, keyLoad, valLoad;
  logic [KEY_REC_W-1:0]   keyRec;
  logic [VAL_REC_W-1:0]   valRec;

  always_comb begin
    isSet = s_axis_tdata[HDR_OPC_LSB +: 8] == OPC_SET;
`ifdef FRONT_END_HDR_CHECK_EN
    hdrOk = (s_axis_tdata[HDR_MAGIC_LSB +: 16] == MAGIC)
         && (s_axis_tdata[HDR_RSVD_LSB +: 16] == 16'h0000)
         && (s_axis_tdata[HDR_KEYLEN_LSB +: 8] != 8'h00)
         && ({8'h00, s_axis_tdata[HDR_KEYLEN_LSB +: 8]} <= s_axis_tdata[HDR_TOTLEN_LSB +: 16]);
`else
    hdrOk = 1'b1;
`endif
    // A rejected header is simply swallowed, so it must not wait on the key slot or allocator.
    hdrReady = hdrOk ? (keyFree && (!isSet || s_free_pointer_valid)) : 1'b1;

    s_axis_tready = 1'b0;
    case (state_q)
      ST_HDR:   s_axis_tready = hdrReady;
      ST_VALUE: s_axis_tready = valFree;
      ST_DROP:  s_axis_tready = 1'b1;
      default:  s_axis_tready = 1'b0;
    endcase
    if (rst) s_axis_tready = 1'b0;

    hdrAccept            = (state_q == ST_HDR) && s_axis_tvalid && s_axis_tready;
    keyLoad              = hdrAccept && hdrOk;
    s_free_pointer_ready = keyLoad && isSet;
    valLoad              = (state_q == ST_VALUE) && s_axis_tvalid && s_axis_tready;

    keyRec = {isSet, (isSet ? s_free_pointer : 16'h0000), s_axis_tdata[HDR_KEY_LSB +: KEY_W]};
    valRec = {ptr_q, beatIdx_q, maskBytes(s_axis_tdata, s_axis_tkeep)};
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= ST_HDR;
      ptr_q     <= '0;
      beatIdx_q <= '0;
    end else begin
      case (state_q)
        ST_HDR: begin
          if (keyLoad) begin
            ptr_q     <= isSet ? s_free_pointer : 16'h0000;
            beatIdx_q <= '0;
          end
          if (hdrAccept) begin
            if (s_axis_tlast)         state_q <= ST_HDR;
            else if (hdrOk && isSet)  state_q <= ST_VALUE;
            else                      state_q <= ST_DROP;
          end
        end
        ST_VALUE: begin
          if (valLoad) begin
            beatIdx_q <= beatIdx_q + 16'd1;
            if (s_axis_tlast) state_q <= ST_HDR;
          end
        end
        ST_DROP: begin
          if (s_axis_tvalid && s_axis_tlast) state_q <= ST_HDR;
        end
        default: state_q <= ST_HDR;
      endcase
    end
  end

  kv_axis_out_reg #(.W(KEY_REC_W)) uKeyReg (
    .clk     (clk),
    .rst     (rst),
    .load_i  (keyLoad),
    .data_i  (keyRec),
    .ready_i (m_key_ready),
    .valid_o (m_key_valid),
    .data_o  (m_key_data),
    .free_o  (keyFree)
  );

  kv_axis_out_reg #(.W(VAL_REC_W)) uValReg (
    .clk     (clk),
    .rst     (rst),
    .load_i  (valLoad),
    .data_i  (valRec),
    .ready_i (m_value_ready),
    .valid_o (m_value_valid),
    .data_o  (m_value_data),
    .free_o  (valFree)
  );

endmodule

// File: tb/tb_kv_front_end_transit.sv
// Scoreboard bench for kv_front_end_transit; expected key/value records are queued as packets are driven.
module tb_kv_front_end_transit;

  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic [511:0] s_axis_tdata = '0;
  logic         s_axis_tvalid = 1'b0;
  logic         s_axis_tready;
  logic         s_axis_tlast = 1'b0;
  logic [63:0]  s_axis_tkeep = '0;
  logic [15:0]  s_free_pointer = '0;
  logic         s_free_pointer_valid = 1'b0;
  logic         s_free_pointer_ready;
  logic [80:0]  m_key_data;
  logic         m_key_valid;
  logic         m_key_ready = 1'b1;
  logic [543:0] m_value_data;
  logic         m_value_valid;
  logic         m_value_ready = 1'b1;

  int vectors = 0;
  int miscompares = 0;
  int ptrCount = 0;
  int stallCount = 0;

  logic [80:0]  keyQ[$];
  logic [543:0] valQ[$];

  localparam logic [511:0] ONES = {512{1'b1}};

  always #5 clk = ~clk;

  kv_front_end_transit dut (
    .clk                  (clk),
    .rst                  (rst),
    .s_axis_tdata         (s_axis_tdata),
    .s_axis_tvalid        (s_axis_tvalid),
    .s_axis_tready        (s_axis_tready),
    .s_axis_tlast         (s_axis_tlast),
    .s_axis_tkeep         (s_axis_tkeep),
    .s_free_pointer       (s_free_pointer),
    .s_free_pointer_valid (s_free_pointer_valid),
    .s_free_pointer_ready (s_free_pointer_ready),
    .m_key_data           (m_key_data),
    .m_key_valid          (m_key_valid),
    .m_key_ready          (m_key_ready),
    .m_value_data         (m_value_data),
    .m_value_valid        (m_value_valid),
    .m_value_ready        (m_value_ready)
  );

  function automatic logic [511:0] mkHdr(input logic [7:0] opc, input logic [7:0] keylen,
                                         input logic [15:0] totlen, input logic [63:0] meta,
                                         input logic [63:0] key, input logic [15:0] magic);
    logic [511:0] h;
    h = {10{32'hDEADBEEF}} << 192;
    h[15:0]    = magic;
    h[31:16]   = 16'h0000;
    h[47:32]   = totlen;
    h[55:48]   = keylen;
    h[63:56]   = opc;
    h[127:64]  = meta;
    h[191:128] = key;
    return h;
  endfunction

  function automatic logic [511:0] keepModel(input logic [511:0] d, input logic [63:0] k);
    logic [511:0] r;
    for (int i = 0; i < 64; i++) r[i*8 +: 8] = k[i] ? d[i*8 +: 8] : 8'h00;
    return r;
  endfunction

  // Output-side scoreboard: every completed output handshake is checked against the queue head.
  always @(negedge clk) begin
    logic [80:0]  expKey;
    logic [543:0] expVal;
    if (!rst && m_key_valid && m_key_ready) begin
      vectors++;
      if (keyQ.size() == 0) begin
        miscompares++;
        $display("[TB] FAIL keyUnexpected got %h want none", m_key_data);
      end else begin
        expKey = keyQ.pop_front();
        if (m_key_data !== expKey) begin
          miscompares++;
          $display("[TB] FAIL keyRecord got %h want %h", m_key_data, expKey);
        end
      end
    end
    if (!rst && m_value_valid && m_value_ready) begin
      vectors++;
      if (valQ.size() == 0) begin
        miscompares++;
        $display("[TB] FAIL valueUnexpected got %h want none", m_value_data);
      end else begin
        expVal = valQ.pop_front();
        if (m_value_data !== expVal) begin
          miscompares++;
          $display("[TB] FAIL valueRecord got %h want %h", m_value_data, expVal);
        end
      end
    end
    if (s_free_pointer_valid && s_free_pointer_ready) ptrCount++;
  end

  // Present one beat and hold it until accepted; returns just after the accepting edge.
  task automatic sendBeat(input logic [511:0] d, input logic [63:0] k, input logic last);
    int waitCycles;
    waitCycles = 0;
    s_axis_tdata  = d;
    s_axis_tkeep  = k;
    s_axis_tlast  = last;
    s_axis_tvalid = 1'b1;
    forever begin
      @(negedge clk);
      if (s_axis_tready) begin
        @(posedge clk); #1;
        break;
      end
      waitCycles++;
      stallCount++;
      if (waitCycles > 100) begin
        vectors++;
        miscompares++;
        $display("[TB] FAIL beatTimeout got tready=0 want 1");
        @(posedge clk); #1;
        break;
      end
    end
  endtask

  task automatic idle(input int n);
    s_axis_tvalid = 1'b0;
    s_axis_tlast  = 1'b0;
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic checkDrained(input string name, input int ptrDelta, input int ptrExp);
    vectors++;
    if (keyQ.size() != 0 || valQ.size() != 0) begin
      miscompares++;
      $display("[TB] FAIL %s_drain got key=%0d val=%0d pending want 0", name, keyQ.size(), valQ.size());
    end
    vectors++;
    if (ptrDelta != ptrExp) begin
      miscompares++;
      $display("[TB] FAIL %s_ptrUsed got %0d want %0d", name, ptrDelta, ptrExp);
    end
  endtask

  task automatic test_reset;
    rst = 1'b1;
    s_axis_tvalid = 1'b1;
    s_axis_tdata  = mkHdr(8'h02, 8'd1, 16'd4, 64'h0, 64'h1234, 16'hFFFF);
    s_axis_tlast  = 1'b1;
    repeat (2) @(posedge clk);
    @(negedge clk);
    vectors++;
    if (m_key_valid !== 1'b0 || m_value_valid !== 1'b0) begin
      miscompares++;
      $display("[TB] FAIL resetValids got %b%b want 00", m_key_valid, m_value_valid);
    end
    vectors++;
    if (s_axis_tready !== 1'b0 || s_free_pointer_ready !== 1'b0) begin
      miscompares++;
      $display("[TB] FAIL resetReadies got %b%b want 00", s_axis_tready, s_free_pointer_ready);
    end
    vectors++;
    if (m_key_data !== 81'h0 || m_value_data !== 544'h0) begin
      miscompares++;
      $display("[TB] FAIL resetData got key=%h want 0", m_key_data);
    end
    @(posedge clk); #1;
    s_axis_tvalid = 1'b0;
    s_axis_tlast  = 1'b0;
    rst = 1'b0;
    idle(2);
  endtask

  task automatic test_set_example;
    int p0;
    p0 = ptrCount;
    s_free_pointer = 16'h0005;
    s_free_pointer_valid = 1'b1;
    keyQ.push_back({1'b1, 16'h0005, 64'h0000_FFFF_FFFF_0000});
    valQ.push_back({16'h0005, 16'h0000, ONES});
    sendBeat(mkHdr(8'h01, 8'd8, 16'd112, {64{1'b1}}, 64'h0000_FFFF_FFFF_0000, 16'hFFFF), {64{1'b1}}, 1'b0);
    vectors++;
    if (m_key_valid !== 1'b1) begin
      miscompares++;
      $display("[TB] FAIL setKeyLatency got %b want 1", m_key_valid);
    end
    sendBeat(ONES, {64{1'b1}}, 1'b1);
    s_axis_tvalid = 1'b0;
    vectors++;
    if (m_value_valid !== 1'b1) begin
      miscompares++;
      $display("[TB] FAIL setValueLatency got %b want 1", m_value_valid);
    end
    idle(3);
    checkDrained("setExample", ptrCount - p0, 1);
  endtask

  task automatic test_non_set;
    int p0;
    p0 = ptrCount;
    s_free_pointer = 16'h0009;
    keyQ.push_back({1'b0, 16'h0000, 64'hCAFE_0000_1111_2222});
    sendBeat(mkHdr(8'h02, 8'd2, 16'd30, 64'h77, 64'hCAFE_0000_1111_2222, 16'hFFFF), {64{1'b1}}, 1'b0);
    sendBeat({16{32'h1357_9BDF}}, {64{1'b1}}, 1'b0);
    sendBeat({16{32'h2468_ACE0}}, {64{1'b1}}, 1'b1);
    idle(3);
    checkDrained("nonSet", ptrCount - p0, 0);
  endtask

  task automatic test_back_to_back;
    int p0, s0;
    logic [511:0] d[4];
    logic [63:0]  k[4];
    p0 = ptrCount;
    s0 = stallCount;
    s_free_pointer = 16'h0010;
    for (int i = 0; i < 4; i++) begin
      d[i] = {16{$urandom}};
      k[i] = {$urandom, $urandom};
    end
    k[3] = 64'h0000_0000_0000_00FF;
    keyQ.push_back({1'b1, 16'h0010, 64'hB2B0_0000_0000_0001});
    for (int i = 0; i < 4; i++) valQ.push_back({16'h0010, i[15:0], keepModel(d[i], k[i])});
    keyQ.push_back({1'b1, 16'h0011, 64'hB2B0_0000_0000_0002});
    sendBeat(mkHdr(8'h01, 8'd1, 16'd9, 64'h0, 64'hB2B0_0000_0000_0001, 16'hFFFF), {64{1'b1}}, 1'b0);
    s_free_pointer = 16'h0011;
    for (int i = 0; i < 4; i++) sendBeat(d[i], k[i], i == 3);
    sendBeat(mkHdr(8'h01, 8'd1, 16'd1, 64'h0, 64'hB2B0_0000_0000_0002, 16'hFFFF), {64{1'b1}}, 1'b1);
    idle(3);
    vectors++;
    if (stallCount - s0 != 0) begin
      miscompares++;
      $display("[TB] FAIL backToBackStalls got %0d want 0", stallCount - s0);
    end
    checkDrained("backToBack", ptrCount - p0, 2);
  endtask

  task automatic test_backpressure;
    int p0;
    logic [511:0] d[3];
    logic [543:0] firstVal;
    p0 = ptrCount;
    s_free_pointer = 16'h0020;
    for (int i = 0; i < 3; i++) d[i] = {16{$urandom}};
    firstVal = {16'h0020, 16'h0000, d[0]};
    keyQ.push_back({1'b1, 16'h0020, 64'h0BAC_0BAC_0BAC_0BAC});
    for (int i = 0; i < 3; i++) valQ.push_back({16'h0020, i[15:0], d[i]});
    m_value_ready = 1'b0;
    fork
      begin
        sendBeat(mkHdr(8'h01, 8'd4, 16'd40, 64'h5, 64'h0BAC_0BAC_0BAC_0BAC, 16'hFFFF), {64{1'b1}}, 1'b0);
        for (int i = 0; i < 3; i++) sendBeat(d[i], {64{1'b1}}, i == 2);
        s_axis_tvalid = 1'b0;
      end
      begin
        int w;
        w = 0;
        while (m_value_valid !== 1'b1 && w < 20) begin
          @(negedge clk);
          w++;
        end
        repeat (4) begin
          @(negedge clk);
          vectors++;
          if (s_axis_tready !== 1'b0) begin
            miscompares++;
            $display("[TB] FAIL bpStall got tready=%b want 0", s_axis_tready);
          end
          vectors++;
          if (m_value_data !== firstVal || m_value_valid !== 1'b1) begin
            miscompares++;
            $display("[TB] FAIL bpHold got %h want %h", m_value_data, firstVal);
          end
        end
        @(posedge clk); #1;
        m_value_ready = 1'b1;
      end
    join
    idle(4);
    checkDrained("backpressure", ptrCount - p0, 1);
  endtask

  task automatic test_no_pointer;
    int p0;
    p0 = ptrCount;
    s_free_pointer_valid = 1'b0;
    s_free_pointer = 16'h0030;
    keyQ.push_back({1'b1, 16'h0030, 64'h0000_0000_0000_0030});
    fork
      begin
        sendBeat(mkHdr(8'h01, 8'd1, 16'd1, 64'h0, 64'h30, 16'hFFFF), {64{1'b1}}, 1'b1);
        s_axis_tvalid = 1'b0;
      end
      begin
        repeat (3) begin
          @(negedge clk);
          vectors++;
          if (s_axis_tready !== 1'b0) begin
            miscompares++;
            $display("[TB] FAIL noPtrStall got tready=%b want 0", s_axis_tready);
          end
        end
        @(posedge clk); #1;
        s_free_pointer_valid = 1'b1;
        @(negedge clk);
        vectors++;
        if (s_axis_tready !== 1'b1 || s_free_pointer_ready !== 1'b1) begin
          miscompares++;
          $display("[TB] FAIL noPtrArrive got tready=%b pready=%b want 11", s_axis_tready, s_free_pointer_ready);
        end
      end
    join
    idle(3);
    checkDrained("noPointer", ptrCount - p0, 1);
  endtask

  task automatic test_bad_magic;
    int p0;
    int expPtr;
    p0 = ptrCount;
    s_free_pointer = 16'h0040;
`ifdef FRONT_END_HDR_CHECK_EN
    expPtr = 0;
`else
    expPtr = 1;
    keyQ.push_back({1'b1, 16'h0040, 64'hBAD0_BAD0_BAD0_BAD0});
    valQ.push_back({16'h0040, 16'h0000, {16{32'h600D_F00D}}});
`endif
    sendBeat(mkHdr(8'h01, 8'd1, 16'd9, 64'h0, 64'hBAD0_BAD0_BAD0_BAD0, 16'h1234), {64{1'b1}}, 1'b0);
    vectors++;
    if (m_key_valid !== (expPtr == 1)) begin
      miscompares++;
      $display("[TB] FAIL badMagicKey got %b want %0d", m_key_valid, expPtr);
    end
    sendBeat({16{32'h600D_F00D}}, {64{1'b1}}, 1'b1);
    idle(3);
    checkDrained("badMagic", ptrCount - p0, expPtr);
  endtask

  task automatic test_reset_mid_value;
    int p0;
    s_free_pointer = 16'h0050;
    m_value_ready = 1'b0;
    keyQ.push_back({1'b1, 16'h0050, 64'h5E5E_0000_0000_0050});
    sendBeat(mkHdr(8'h01, 8'd1, 16'd9, 64'h0, 64'h5E5E_0000_0000_0050, 16'hFFFF), {64{1'b1}}, 1'b0);
    sendBeat({16{32'hAAAA_5555}}, {64{1'b1}}, 1'b0);
    s_axis_tvalid = 1'b0;
    @(posedge clk); #1;
    rst = 1'b1;
    @(negedge clk);
    vectors++;
    if (s_axis_tready !== 1'b0) begin
      miscompares++;
      $display("[TB] FAIL midResetReady got %b want 0", s_axis_tready);
    end
    @(posedge clk); #1;
    rst = 1'b0;
    vectors++;
    if (m_key_valid !== 1'b0 || m_value_valid !== 1'b0) begin
      miscompares++;
      $display("[TB] FAIL midResetValids got %b%b want 00", m_key_valid, m_value_valid);
    end
    m_value_ready = 1'b1;
    idle(1);
    p0 = ptrCount;
    s_free_pointer = 16'h0051;
    keyQ.push_back({1'b1, 16'h0051, 64'h5E5E_0000_0000_0051});
    valQ.push_back({16'h0051, 16'h0000, {16{32'h0F0F_1234}}});
    sendBeat(mkHdr(8'h01, 8'd1, 16'd9, 64'h0, 64'h5E5E_0000_0000_0051, 16'hFFFF), {64{1'b1}}, 1'b0);
    sendBeat({16{32'h0F0F_1234}}, {64{1'b1}}, 1'b1);
    idle(3);
    checkDrained("afterReset", ptrCount - p0, 1);
  endtask

  initial begin
    test_reset();
    test_set_example();
    test_non_set();
    test_back_to_back();
    test_backpressure();
    test_no_pointer();
    test_bad_magic();
    test_reset_mid_value();
    idle(2);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
